// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory subsystem. Decodes core accesses to a
// word-addressed data RAM or a 4 KiB MMIO window holding a TX FIFO feeding
// an 8N1 serial transmitter and a status register. Read data is registered.
// Optional feature macro: DMEM_CYCLE_CNT_EN adds a free-running 32-bit cycle
// counter readable at MMIO offset 0x8 (reads 0 when the macro is undefined).
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module dmem_mmio #(
  parameter int unsigned DMEM_WORDS   = 1024,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [31:0] MMIO_BASE    = 32'h1000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [`WORD_LEN-1:0] addr_d,
  input  logic                 wen,
  input  logic [`WORD_LEN-1:0] wdata,
  output logic [`WORD_LEN-1:0] rdata,
  output logic                 uart_tx
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  localparam logic [FW:0]   FIFO_FULL = (FW+1)'(FIFO_DEPTH);
  localparam logic [FW:0]   CNT_ONE   = (FW+1)'(1);
  localparam logic [FW-1:0] PTR_ONE   = FW'(1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [9:0]    OFF_TXDATA = 10'd0;
  localparam logic [9:0]    OFF_STATUS = 10'd1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Address decode (byte lane bits are ignored: word accesses only)
  logic          mmio_sel_s;
  logic [9:0]    mmio_off_s;
  logic [AW-1:0] ram_idx_s;
  logic          unused_s;

  assign mmio_sel_s = (addr_d[31:12] == MMIO_BASE[31:12]);
  assign mmio_off_s = addr_d[11:2];
  assign ram_idx_s  = addr_d[AW+1:2];
  assign unused_s   = &{1'b0, addr_d[1:0]};

  // Storage and state
  logic [31:0]    mem_r [DMEM_WORDS];
  logic [31:0]    rdata_r;
  logic [7:0]     fifo_mem_r [FIFO_DEPTH];
  logic [FW-1:0]  wr_ptr_r;
  logic [FW-1:0]  rd_ptr_r;
  logic [FW:0]    count_r;
  logic           overflow_r;
  tx_state_t      state_r, state_nx_s;
  logic [BW-1:0]  baud_r, baud_nx_s;
  logic [2:0]     bit_r, bit_nx_s;
  logic [7:0]     shift_r, shift_nx_s;
  logic           tx_r, tx_nx_s;
  logic           pop_s;
  logic [31:0]    mmio_rdata_s;

  logic fifo_empty_s, fifo_full_s, tx_busy_s;
  logic push_req_s, push_ok_s, status_wr_s;

  assign fifo_empty_s = (count_r == '0);
  assign fifo_full_s  = (count_r == FIFO_FULL);
  assign tx_busy_s    = (state_r != TX_IDLE);
  assign push_req_s   = wen && mmio_sel_s && (mmio_off_s == OFF_TXDATA);
  // Acceptance looks only at the pre-edge count, so a same-edge pop never makes room
  assign push_ok_s    = push_req_s && !fifo_full_s;
  assign status_wr_s  = wen && mmio_sel_s && (mmio_off_s == OFF_STATUS);

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cycle_r;

  // Free-running cycle counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_r <= 32'd0;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end
`endif

  // MMIO read mux; status reflects pre-edge register values
  always_comb begin
    mmio_rdata_s = 32'd0;
    case (mmio_off_s)
      OFF_STATUS: mmio_rdata_s = {28'd0, overflow_r, tx_busy_s, fifo_empty_s, fifo_full_s};
`ifdef DMEM_CYCLE_CNT_EN
      10'd2:      mmio_rdata_s = cycle_r;
`endif
      default:    mmio_rdata_s = 32'd0;
    endcase
  end

  // Data RAM write port (contents deliberately not reset)
  always_ff @(posedge clk) begin
    if (wen && !mmio_sel_s) begin
      mem_r[ram_idx_s] <= wdata;
    end
  end

  // Registered read data; RAM read sees the old word on a same-edge write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'd0;
    end else begin
      rdata_r <= mmio_sel_s ? mmio_rdata_s : mem_r[ram_idx_s];
    end
  end

  // TX FIFO byte storage
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= wdata[7:0];
    end
  end

  // TX FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (push_req_s && fifo_full_s) begin
        overflow_r <= 1'b1;
      end else if (status_wr_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Transmitter state register; line output is a flop so it never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= TX_IDLE;
      baud_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_nx_s;
      baud_r  <= baud_nx_s;
      bit_r   <= bit_nx_s;
      shift_r <= shift_nx_s;
      tx_r    <= tx_nx_s;
    end
  end

  // Transmitter next-state: start bit, 8 data bits LSB first, stop bit
  always_comb begin
    state_nx_s = state_r;
    baud_nx_s  = baud_r;
    bit_nx_s   = bit_r;
    shift_nx_s = shift_r;
    tx_nx_s    = tx_r;
    pop_s      = 1'b0;
    case (state_r)
      TX_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          shift_nx_s = fifo_mem_r[rd_ptr_r];
          state_nx_s = TX_START;
          baud_nx_s  = '0;
          tx_nx_s    = 1'b0;
        end else begin
          tx_nx_s    = 1'b1;
        end
      end
      TX_START: begin
        if (baud_r == BAUD_LAST) begin
          state_nx_s = TX_DATA;
          baud_nx_s  = '0;
          bit_nx_s   = 3'd0;
          tx_nx_s    = shift_r[0];
          shift_nx_s = {1'b0, shift_r[7:1]};
        end else begin
          baud_nx_s  = baud_r + BAUD_ONE;
        end
      end
      TX_DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_nx_s = '0;
          if (bit_r == 3'd7) begin
            state_nx_s = TX_STOP;
            tx_nx_s    = 1'b1;
          end else begin
            bit_nx_s   = bit_r + 3'd1;
            tx_nx_s    = shift_r[0];
            shift_nx_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          baud_nx_s = baud_r + BAUD_ONE;
        end
      end
      TX_STOP: begin
        if (baud_r == BAUD_LAST) begin
          state_nx_s = TX_IDLE;
          baud_nx_s  = '0;
          tx_nx_s    = 1'b1;
        end else begin
          baud_nx_s  = baud_r + BAUD_ONE;
        end
      end
      default: begin
        state_nx_s = TX_IDLE;
        baud_nx_s  = '0;
        tx_nx_s    = 1'b1;
      end
    endcase
  end

  assign rdata   = rdata_r;
  assign uart_tx = tx_r;

endmodule
